// File: rtl/test_monitor.sv
// End-of-test monitor: snoops writeback/store ports, freezes a pass/fail/timeout verdict.
// Optional signature buffer compiled in with `define TEST_MON_SIGNATURE_EN.
module test_monitor #(
    parameter int unsigned END_REG        = 26,
    parameter int unsigned PASS_REG       = 27,
    parameter int unsigned TNUM_REG       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 768,
    parameter int unsigned DRAIN_CYCLES   = 2,
    parameter logic [31:0] SIG_BASE       = 32'h0000_1000,
    parameter int unsigned SIG_DEPTH      = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_en,
    input  logic [4:0]                   wb_addr,
    input  logic [31:0]                  wb_data,
    input  logic                         st_en,
    input  logic [31:0]                  st_addr,
    input  logic [31:0]                  st_data,
    input  logic [3:0]                   st_strb,
    input  logic [$clog2(SIG_DEPTH)-1:0] sig_raddr,
    output logic [31:0]                  sig_rdata,
    output logic                         done,
    output logic                         pass,
    output logic                         fail,
    output logic                         timeout,
    output logic [31:0]                  fail_tnum,
    output logic [31:0]                  cycle_cnt
);

    localparam logic [4:0]  EndIdx  = 5'(END_REG);
    localparam logic [4:0]  PassIdx = 5'(PASS_REG);
    localparam logic [4:0]  TnumIdx = 5'(TNUM_REG);
    localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] DrnLoad = 32'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {StRun, StDrain, StFinal} state_e;

    state_e      state_q, state_d;
    logic [31:0] tnum_q, tnum_d, passv_q, passv_d;
    logic [31:0] drain_q, drain_d, cnt_q, cnt_d, ftnum_q, ftnum_d;
    logic        done_q, done_d, vpass_q, vpass_d, fail_q, fail_d, tmo_q, tmo_d;
    logic        active, wb_valid, end_evt;

    always_comb begin
        active   = (state_q != StFinal);
        wb_valid = wb_en && (wb_addr != 5'd0);
        end_evt  = wb_valid && (wb_addr == EndIdx) && (wb_data == 32'd1);

        tnum_d  = tnum_q;
        passv_d = passv_q;
        if (active && wb_valid && (wb_addr == TnumIdx)) tnum_d  = wb_data;
        if (active && wb_valid && (wb_addr == PassIdx)) passv_d = wb_data;

        state_d = state_q;
        drain_d = drain_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        vpass_d = vpass_q;
        fail_d  = fail_q;
        tmo_d   = tmo_q;
        ftnum_d = ftnum_q;

        case (state_q)
            StRun: begin
                // End event takes priority over a coincident timeout.
                if (end_evt) begin
                    state_d = StDrain;
                    drain_d = DrnLoad;
                end else if (cnt_q == TmoLast) begin
                    state_d = StFinal;
                    done_d  = 1'b1;
                    tmo_d   = 1'b1;
                    fail_d  = 1'b1;
                    vpass_d = 1'b0;
                    ftnum_d = tnum_q;
                end else if (cnt_q != 32'hFFFF_FFFF) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StDrain: begin
                if (drain_q == 32'd0) begin
                    state_d = StFinal;
                    done_d  = 1'b1;
                    vpass_d = (passv_d == 32'd1);
                    fail_d  = (passv_d != 32'd1);
                    ftnum_d = tnum_d;
                end else begin
                    drain_d = drain_q - 32'd1;
                end
            end
            StFinal: ;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            tnum_q  <= '0;
            passv_q <= '0;
            drain_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            vpass_q <= 1'b0;
            fail_q  <= 1'b0;
            tmo_q   <= 1'b0;
            ftnum_q <= '0;
        end else begin
            state_q <= state_d;
            tnum_q  <= tnum_d;
            passv_q <= passv_d;
            drain_q <= drain_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            vpass_q <= vpass_d;
            fail_q  <= fail_d;
            tmo_q   <= tmo_d;
            ftnum_q <= ftnum_d;
        end
    end

    assign done      = done_q;
    assign pass      = vpass_q;
    assign fail      = fail_q;
    assign timeout   = tmo_q;
    assign fail_tnum = ftnum_q;
    assign cycle_cnt = cnt_q;

`ifdef TEST_MON_SIGNATURE_EN
    localparam int unsigned Aw = $clog2(SIG_DEPTH);

    logic [31:0]   sig_mem [SIG_DEPTH];
    logic [31:0]   sig_rdata_q;
    logic [31:0]   st_off;
    logic          st_hit;
    logic [Aw-1:0] st_idx;
    logic          unused_st_lsb;

    always_comb begin
        st_off = st_addr - SIG_BASE;
        st_hit = st_en && active && !rst && (st_addr >= SIG_BASE) &&
                 (st_off[31:2] < 30'(SIG_DEPTH));
        st_idx = st_off[Aw+1:2];
    end
    assign unused_st_lsb = ^st_off[1:0];

    always_ff @(posedge clk) begin
        if (st_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (st_strb[b]) sig_mem[st_idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

    // Read-before-write: a same-index write this cycle is not forwarded.
    always_ff @(posedge clk) begin
        if (rst) sig_rdata_q <= '0;
        else     sig_rdata_q <= sig_mem[sig_raddr];
    end

    assign sig_rdata = sig_rdata_q;
`else
    logic unused_sig;
    assign unused_sig = ^{st_en, st_addr, st_data, st_strb, sig_raddr};
    assign sig_rdata  = 32'd0;
`endif

endmodule
